mono_data_tx_emu: RTL

MONO_DATA_TX_EMU -- requirements
Module: mono_data_tx_emu

---
 rtl/mono_data_tx_emu.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mono_data_tx_emu.sv
// Emulates a monolithic sensor's token/serial readout port: staged hits are queued, then shifted out.
// Optional sent-word counter at addr 9/10 is built in when MONO_DATA_TX_SENT_CNT_EN is defined.
module mono_data_tx_emu #(
   parameter int unsigned ABUSWIDTH = 16,
   parameter int unsigned DEPTH     = 16
) (
   input  logic                 BUS_CLK,
   input  logic                 RST,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 BUS_WR,
   input  logic                 BUS_RD,
   input  logic                 READ,
   input  logic                 FREEZE,
   output logic                 TOKEN,
   output logic                 DATA
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [7:0] Version = 8'd1;

   typedef enum logic [1:0] {StIdle, StToken, StLoad, StShift} state_e;

   state_e        state_q, state_d;
   logic          soft_rst_q, rst;
   logic          en_q, gray_dis_q, ovf_q;
   logic [5:0]    col_q;
   logic [7:0]    row_q, te_q, le_q;
   logic [29:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [29:0]   shift_q, shift_d, head, load_word;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic          data_q, data_d, token_q;
   logic          read_q, read_prev_q, read_rise;
   logic [7:0]    bus_data_q, rd_data;
   logic [7:0]    le_h, te_h, le_x, te_x;
   logic          fifo_empty, fifo_full, push_req, push, pop, busy;

   // A write to addr 0 is registered, then behaves exactly like RST.
   assign rst = RST | soft_rst_q;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign pop        = (state_q == StLoad);
   assign push_req   = BUS_WR && (BUS_ADD == ABUSWIDTH'(5));
   assign push       = push_req && (!fifo_full || pop);
   assign busy       = (state_q == StLoad) || (state_q == StShift);
   assign read_rise  = read_q && !read_prev_q;

   assign head      = mem_q[rd_ptr_q];
   assign le_h      = head[29:22];
   assign te_h      = head[21:14];
   assign le_x      = gray_dis_q ? le_h : (le_h ^ (le_h >> 1));
   assign te_x      = gray_dis_q ? te_h : (te_h ^ (te_h >> 1));
   assign load_word = {le_x, te_x, head[13:0]};

`ifdef MONO_DATA_TX_SENT_CNT_EN
   logic [15:0] sent_cnt_q;
   always_ff @(posedge BUS_CLK) begin
      if (rst) sent_cnt_q <= '0;
      else if (state_q == StLoad) sent_cnt_q <= sent_cnt_q + 16'd1;
   end
`endif

   always_comb begin
      count_d = count_q;
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = 1'b0;
      unique case (state_q)
         StIdle: if (en_q && !fifo_empty && !FREEZE) state_d = StToken;
         StToken: begin
            if (!en_q) state_d = StIdle;
            else if (read_rise) state_d = StLoad;
         end
         StLoad: begin
            data_d    = load_word[29];
            shift_d   = {load_word[28:0], 1'b0};
            bit_cnt_d = '0;
            state_d   = StShift;
         end
         StShift: begin
            // bit_cnt_q == 29 is the cycle showing the last bit; FREEZE is not consulted here.
            if (bit_cnt_q == 5'd29) begin
               state_d = (!fifo_empty && en_q) ? StToken : StIdle;
            end else begin
               data_d    = shift_q[29];
               shift_d   = {shift_q[28:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_data = 8'h00;
      case (BUS_ADD)
         ABUSWIDTH'(0):  rd_data = Version;
         ABUSWIDTH'(6):  rd_data = 8'(count_q);
         ABUSWIDTH'(7):  rd_data = {5'b0, ovf_q, token_q, busy};
         ABUSWIDTH'(8):  rd_data = {6'b0, gray_dis_q, en_q};
`ifdef MONO_DATA_TX_SENT_CNT_EN
         ABUSWIDTH'(9):  rd_data = sent_cnt_q[7:0];
         ABUSWIDTH'(10): rd_data = sent_cnt_q[15:8];
`endif
         default:        rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (RST) soft_rst_q <= 1'b0;
      else soft_rst_q <= BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
   end

   always_ff @(posedge BUS_CLK) begin
      if (push) mem_q[wr_ptr_q] <= {le_q, te_q, row_q, col_q};
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst) begin
         state_q     <= StIdle;
         en_q        <= 1'b0;
         gray_dis_q  <= 1'b0;
         ovf_q       <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         te_q        <= '0;
         le_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         data_q      <= 1'b0;
         token_q     <= 1'b0;
         read_q      <= 1'b0;
         read_prev_q <= 1'b0;
         bus_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         data_q      <= data_d;
         token_q     <= (state_d != StIdle);
         read_q      <= READ;
         read_prev_q <= read_q;
         count_q     <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
         if (BUS_RD) bus_data_q <= rd_data;
         if (BUS_WR) begin
            case (BUS_ADD)
               ABUSWIDTH'(1): col_q <= BUS_DATA_IN[5:0];
               ABUSWIDTH'(2): row_q <= BUS_DATA_IN;
               ABUSWIDTH'(3): te_q  <= BUS_DATA_IN;
               ABUSWIDTH'(4): le_q  <= BUS_DATA_IN;
               ABUSWIDTH'(8): begin
                  en_q       <= BUS_DATA_IN[0];
                  gray_dis_q <= BUS_DATA_IN[1];
               end
               default: ;
            endcase
         end
      end
   end

   assign BUS_DATA_OUT = bus_data_q;
   assign TOKEN        = token_q;
   assign DATA         = data_q;

endmodule
